mac_rx_frame_sequencer: RTL and testbench

Front-end controller for the MAC frame-check path. It watches the 64-bit data / 8-bit control receive stream and finds frames by START_CODE and TERM_CODE. Each frame is written word by word into an external frame buffer. A complete frame is handed to the downstream checker through a valid/ready descriptor handshake. The block drops malformed, oversize and overlapping frames and keeps frame and drop counters.

---
 rtl/mac_rx_frame_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mac_rx_frame_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_frame_sequencer.sv
// Purpose: delimits receive frames by START/TERM control codes, writes them to a frame buffer, hands a descriptor to the checker.
// Latency: buffer write one cycle after the word is sampled; descriptor valid two cycles after the term word.
// Backpressure: descriptor held until i_frame_ready; overlapping starts while waiting are counted and discarded.
module mac_rx_frame_sequencer #(
    parameter int          DATA_WIDTH      = 64,
    parameter int          CTRL_WIDTH      = 8,
    parameter int          BUF_WORDS       = 192,
    parameter int          ADDR_W          = $clog2(BUF_WORDS),
    parameter int          MIN_FRAME_BYTES = 73,
    parameter logic [7:0]  START_CODE      = 8'hFB,
    parameter logic [7:0]  TERM_CODE       = 8'hFD,
    parameter logic [7:0]  IDLE_CODE       = 8'h07
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    input  logic                  i_rx_valid,
    output logic                  o_wr_en,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_frame_valid,
    input  logic                  i_frame_ready,
    output logic [15:0]           o_frame_len,
    output logic                  o_frame_runt,
    output logic [15:0]           o_frame_count,
    output logic [15:0]           o_drop_count
);

    // Word index must reach BUF_WORDS itself so a full buffer is detectable.
    localparam int IDX_W   = $clog2(BUF_WORDS + 1);
    localparam int LANE_W  = $clog2(CTRL_WIDTH);
    localparam int BYTE_SH = $clog2(CTRL_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_HANDOFF,
        S_DROP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d, pend_now;
    logic               has_ctrl, any_term, is_start, is_term, is_idle;
    logic [LANE_W-1:0]  lane_t;
    logic [7:0]         lane_b;
    logic               wr_en_d, len_ld, drop_inc, frame_inc, valid_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [15:0]        len_d;

    // Lane decode: lowest control lane wins; any lane carrying TERM is also noted for start+term words.
    always_comb begin
        has_ctrl = 1'b0;
        lane_t   = '0;
        lane_b   = '0;
        any_term = 1'b0;
        for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
            if (i_rx_ctrl[i]) begin
                has_ctrl = 1'b1;
                lane_t   = LANE_W'(i);
                lane_b   = i_rx_data[8*i +: 8];
                if (i_rx_data[8*i +: 8] == TERM_CODE) begin
                    any_term = 1'b1;
                end
            end
        end
    end

    assign is_start = i_rx_ctrl[0] && (i_rx_data[7:0] == START_CODE);
    assign is_term  = has_ctrl && (lane_b == TERM_CODE);
    assign is_idle  = has_ctrl && (lane_b == IDLE_CODE);
    assign len_d    = (16'(idx_q) << BYTE_SH) + 16'(lane_t) + 16'd1;

    // Next-state and per-cycle actions of the frame sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        pend_now  = pending_q;
        wr_en_d   = 1'b0;
        wr_addr_d = idx_q[ADDR_W-1:0];
        len_ld    = 1'b0;
        drop_inc  = 1'b0;
        frame_inc = 1'b0;
        valid_d   = o_frame_valid;
        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && is_start) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    idx_d     = IDX_W'(1);
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (i_rx_valid) begin
                    if (is_start) begin
                        drop_inc  = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        idx_d     = IDX_W'(1);
                    end else if (idx_q == IDX_W'(BUF_WORDS)) begin
                        drop_inc = 1'b1;
                        state_d  = S_DROP;
                    end else if (!has_ctrl) begin
                        wr_en_d = 1'b1;
                        idx_d   = idx_q + IDX_W'(1);
                    end else if (is_term) begin
                        wr_en_d = 1'b1;
                        len_ld  = 1'b1;
                        state_d = S_HANDOFF;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_HANDOFF: begin
                if (i_rx_valid) begin
                    if (is_start) begin
                        drop_inc = 1'b1;
                        pend_now = !any_term;
                    end else if (is_term || is_idle) begin
                        pend_now = 1'b0;
                    end
                end
                pending_d = pend_now;
                if (o_frame_valid && i_frame_ready) begin
                    valid_d   = 1'b0;
                    frame_inc = 1'b1;
                    pending_d = 1'b0;
                    state_d   = pend_now ? S_DROP : S_IDLE;
                end else if (!o_frame_valid) begin
                    valid_d = 1'b1;
                end
            end
            S_DROP: begin
                if (i_rx_valid && (is_term || is_idle)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, write port, descriptor and saturating counters.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_frame_valid <= 1'b0;
            o_frame_len   <= '0;
            o_frame_runt  <= 1'b0;
            o_frame_count <= '0;
            o_drop_count  <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            o_wr_en       <= wr_en_d;
            o_frame_valid <= valid_d;
            if (wr_en_d) begin
                o_wr_addr <= wr_addr_d;
                o_wr_data <= i_rx_data;
            end
            if (len_ld) begin
                o_frame_len  <= len_d;
                o_frame_runt <= (len_d < 16'(MIN_FRAME_BYTES));
            end
            if (frame_inc && (o_frame_count != 16'hFFFF)) begin
                o_frame_count <= o_frame_count + 16'd1;
            end
            if (drop_inc && (o_drop_count != 16'hFFFF)) begin
                o_drop_count <= o_drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_frame_sequencer.sv
// Purpose: directed frame scenarios plus random traffic against a byte-counting reference model.
// Latency: model predicts registered outputs after each rising edge; compared on the falling edge.
// Backpressure: i_frame_ready is held low, pulsed, or randomised to exercise descriptor holding.
module tb_mac_rx_frame_sequencer;

    localparam int BUFW = 192;

    logic        clk;
    logic        i_rst;
    logic [63:0] i_rx_data;
    logic [7:0]  i_rx_ctrl;
    logic        i_rx_valid;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [63:0] o_wr_data;
    logic        o_frame_valid;
    logic        i_frame_ready;
    logic [15:0] o_frame_len;
    logic        o_frame_runt;
    logic [15:0] o_frame_count;
    logic [15:0] o_drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mac_rx_frame_sequencer dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_rx_data     (i_rx_data),
        .i_rx_ctrl     (i_rx_ctrl),
        .i_rx_valid    (i_rx_valid),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_frame_len   (o_frame_len),
        .o_frame_runt  (o_frame_runt),
        .o_frame_count (o_frame_count),
        .o_drop_count  (o_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 waiting for start, 1 collecting, 2 descriptor out, 3 discarding.
    int          m_mode, m_bytes, m_len, m_frames, m_drops;
    bit          m_pend, m_vis, m_runt, e_wr;
    int          e_addr;
    logic [63:0] e_data;

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    function automatic void lane_info(input logic [63:0] d, input logic [7:0] c,
                                      output bit has, output int t, output logic [7:0] b,
                                      output bit aterm);
        has = 0; t = 0; b = 8'h00; aterm = 0;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                if (!has) begin
                    has = 1; t = i; b = d[8*i +: 8];
                end
                if (d[8*i +: 8] == 8'hFD) aterm = 1;
            end
        end
    endfunction

    always @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            m_mode = 0; m_bytes = 0; m_len = 0; m_frames = 0; m_drops = 0;
            m_pend = 0; m_vis = 0; m_runt = 0; e_wr = 0; e_addr = 0; e_data = '0;
        end else begin : model_step
            int          mode0, t;
            bit          has, aterm, st, hs;
            logic [7:0]  b;
            mode0 = m_mode;
            hs    = (mode0 == 2) && m_vis && i_frame_ready;
            e_wr  = 0;
            if (i_rx_valid) begin
                lane_info(i_rx_data, i_rx_ctrl, has, t, b, aterm);
                st = i_rx_ctrl[0] && (i_rx_data[7:0] == 8'hFB);
                case (mode0)
                    0: if (st) begin
                        e_wr = 1; e_addr = 0; e_data = i_rx_data; m_bytes = 8; m_mode = 1;
                    end
                    1: begin
                        if (st) begin
                            m_drops = sat(m_drops);
                            e_wr = 1; e_addr = 0; e_data = i_rx_data; m_bytes = 8;
                        end else if (m_bytes >= BUFW * 8) begin
                            m_drops = sat(m_drops); m_mode = 3;
                        end else if (!has) begin
                            e_wr = 1; e_addr = m_bytes / 8; e_data = i_rx_data; m_bytes += 8;
                        end else if (b == 8'hFD) begin
                            e_wr = 1; e_addr = m_bytes / 8; e_data = i_rx_data;
                            m_len = m_bytes + t + 1; m_runt = (m_len < 73);
                            m_mode = 2; m_vis = 0;
                        end else begin
                            m_drops = sat(m_drops); m_mode = 0;
                        end
                    end
                    2: begin
                        if (st) begin
                            m_drops = sat(m_drops); m_pend = !aterm;
                        end else if (has && (b == 8'hFD || b == 8'h07)) begin
                            m_pend = 0;
                        end
                    end
                    default: if (has && (b == 8'hFD || b == 8'h07)) m_mode = 0;
                endcase
            end
            if (mode0 == 2) begin
                if (hs) begin
                    m_frames = sat(m_frames); m_vis = 0;
                    m_mode = m_pend ? 3 : 0; m_pend = 0;
                end else begin
                    m_vis = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en", o_wr_en, e_wr);
            if (e_wr) begin
                chk("wr_addr", o_wr_addr, e_addr);
                chk("wr_data", o_wr_data, e_data);
            end
            chk("frame_valid", o_frame_valid, m_vis);
            chk("frame_len", o_frame_len, m_len);
            chk("frame_runt", o_frame_runt, m_runt);
            chk("frame_count", o_frame_count, m_frames);
            chk("drop_count", o_drop_count, m_drops);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] start_d();
        logic [63:0] d;
        d = rnd64();
        d[7:0] = 8'hFB;
        return d;
    endfunction

    function automatic logic [63:0] code_d(input int t, input logic [7:0] code);
        logic [63:0] d;
        d = rnd64();
        for (int i = 0; i < 8; i++) if (i > t) d[8*i +: 8] = 8'h07;
        d[8*t +: 8] = code;
        return d;
    endfunction

    task automatic send(input logic [63:0] d, input logic [7:0] c);
        i_rx_data  = d;
        i_rx_ctrl  = c;
        i_rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_idle();
        send(64'h0707070707070707, 8'hFF);
    endtask

    task automatic send_frame(input int ndata, input int t);
        send(start_d(), 8'h01);
        repeat (ndata) send(rnd64(), 8'h00);
        send(code_d(t, 8'hFD), 8'(8'hFF << t));
    endtask

    task automatic handshake();
        i_frame_ready = 1'b1;
        send_idle();
        i_frame_ready = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_valid", o_frame_valid, 0);
        chk("rst_len", o_frame_len, 0);
        chk("rst_frames", o_frame_count, 0);
        chk("rst_drops", o_drop_count, 0);
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int d0, c0;
        i_rst = 1'b1; i_rx_data = '0; i_rx_ctrl = '0; i_rx_valid = 1'b0; i_frame_ready = 1'b0;
        @(negedge clk);
        chk("reset_wr_en", o_wr_en, 0);
        chk("reset_wr_addr", o_wr_addr, 0);
        chk("reset_valid", o_frame_valid, 0);
        chk("reset_len", o_frame_len, 0);
        chk("reset_counts", {o_frame_count, o_drop_count}, 0);
        @(negedge clk);
        i_rst  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // 1: minimum frame, held descriptor, then handshake
        send_frame(8, 0);
        chk("t1_last_wr", {o_wr_en, o_wr_addr}, {1'b1, 8'd9});
        chk("t1_valid_not_yet", o_frame_valid, 0);
        send_idle();
        chk("t1_valid", o_frame_valid, 1);
        chk("t1_len", o_frame_len, 73);
        chk("t1_runt", o_frame_runt, 0);
        send_idle(); send_idle();
        chk("t1_hold", {o_frame_valid, o_frame_len}, {1'b1, 16'd73});
        handshake();
        chk("t1_count", o_frame_count, 1);
        chk("t1_valid_fall", o_frame_valid, 0);

        // 2: term in lane 5 of word 20, then a runt
        send_frame(19, 5); send_idle();
        chk("t2_len", o_frame_len, 166);
        handshake();
        send_frame(6, 4); send_idle();
        chk("t2_runt_len", o_frame_len, 61);
        chk("t2_runt", o_frame_runt, 1);
        handshake();

        // 3: error character aborts, next frame clean
        d0 = o_drop_count;
        send(start_d(), 8'h01);
        repeat (5) send(rnd64(), 8'h00);
        send(code_d(3, 8'hFE), 8'h08);
        chk("t3_drop", o_drop_count, d0 + 1);
        send_idle();
        chk("t3_no_valid", o_frame_valid, 0);
        send_frame(8, 0); send_idle();
        chk("t3_next_len", {o_frame_valid, o_frame_len}, {1'b1, 16'd73});
        handshake();

        // 4: overflow
        d0 = o_drop_count;
        send(start_d(), 8'h01);
        repeat (191) send(rnd64(), 8'h00);
        chk("t4_last_wr", {o_wr_en, o_wr_addr}, {1'b1, 8'd191});
        send(rnd64(), 8'h00);
        chk("t4_no_wr", o_wr_en, 0);
        chk("t4_drop", o_drop_count, d0 + 1);
        repeat (3) send(rnd64(), 8'h00);
        send(start_d(), 8'h01);
        chk("t4_start_ignored", o_wr_en, 0);
        send_idle();
        send_frame(8, 0); send_idle();
        chk("t4_next_valid", o_frame_valid, 1);
        handshake();

        // 5: overlapping start while descriptor waits
        c0 = o_frame_count; d0 = o_drop_count;
        send_frame(8, 0);
        send(start_d(), 8'h01);
        repeat (3) send(rnd64(), 8'h00);
        chk("t5_drop", o_drop_count, d0 + 1);
        chk("t5_hold", o_frame_valid, 1);
        handshake();
        send(rnd64(), 8'h00); send(rnd64(), 8'h00);
        chk("t5_discard", o_wr_en, 0);
        send(code_d(0, 8'hFD), 8'hFF);
        send(start_d(), 8'h01);
        chk("t5_third_addr", {o_wr_en, o_wr_addr}, {1'b1, 8'd0});
        repeat (8) send(rnd64(), 8'h00);
        send(code_d(0, 8'hFD), 8'hFF);
        send_idle();
        handshake();
        chk("t5_count", o_frame_count, c0 + 2);

        // 6: async reset mid-capture and mid-handoff
        send(start_d(), 8'h01);
        repeat (3) send(rnd64(), 8'h00);
        async_reset();
        send(start_d(), 8'h01);
        chk("t6_restart_addr", {o_wr_en, o_wr_addr}, {1'b1, 8'd0});
        repeat (8) send(rnd64(), 8'h00);
        send(code_d(0, 8'hFD), 8'hFF);
        send_idle();
        async_reset();
        send(start_d(), 8'h01);
        chk("t6_restart2_addr", {o_wr_en, o_wr_addr}, {1'b1, 8'd0});

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            int r, t;
            r = $urandom_range(0, 99);
            t = $urandom_range(0, 7);
            i_frame_ready = ($urandom_range(0, 1) == 1);
            i_rx_valid    = ($urandom_range(0, 9) != 0);
            if (r < 5) begin
                i_rx_data = start_d(); i_rx_ctrl = 8'h01 | 8'($urandom_range(0, 255) & 8'hF0);
            end else if (r < 10) begin
                i_rx_data = code_d(t, 8'hFD); i_rx_ctrl = 8'(8'hFF << t);
            end else if (r < 14) begin
                i_rx_data = 64'h0707070707070707; i_rx_ctrl = 8'hFF;
            end else if (r < 15) begin
                i_rx_data = code_d(t, 8'hFE); i_rx_ctrl = 8'(8'h01 << t);
            end else begin
                i_rx_data = rnd64(); i_rx_ctrl = 8'h00;
            end
            @(negedge clk);
        end

        i_rx_valid = 1'b0; i_frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
